// File: rtl/bram_arbiter.sv
// Shares one single-port frame-buffer BRAM between a buffered pixel writer and a frame reader.
// Optional BRAM_ARBITER_STATS_EN builds a saturating dropped-pixel counter on o_drop_cnt.
module bram_arbiter #(
    parameter int DATA_WIDTH   = 12,
    parameter int DEPTH        = 307200,
    parameter int ADDR_WIDTH   = 19,
    parameter int WBUF_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wvalid,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_sof,
    output logic                  o_woverflow,
    input  logic                  i_req,
    input  logic                  i_almostfull,
    output logic                  o_wr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic [15:0]           o_drop_cnt
);
    localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CW = $clog2(WBUF_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    typedef struct packed {
        logic                  sof;
        logic [DATA_WIDTH-1:0] dat;
    } wentry_t;

    state_t                state_q, state_d;
    wentry_t               wbuf_q [WBUF_DEPTH];
    wentry_t               wbuf_d [WBUF_DEPTH];
    logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  rd_active_q, rd_active_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  ovf_q, ovf_d;

    logic                  rd_elig, pop, push, drop;
    logic [ADDR_WIDTH-1:0] wr_seq_addr, wr_used_addr;
    wentry_t               head;

    always_comb begin
        rd_elig  = rd_active_q & ~i_almostfull;
        head     = wbuf_q[rp_q];
        state_d  = IDLE;
        if (!i_rst) begin
            if (rd_elig && starve_q >= SW'(STARVE_LIMIT)) state_d = READ;
            else if (count_q != '0)                        state_d = WRITE;
            else if (rd_elig)                              state_d = READ;
        end

        pop  = (state_d == WRITE);
        push = i_wvalid & ((count_q != CW'(WBUF_DEPTH)) | pop);
        drop = i_wvalid & ~push;

        wr_seq_addr  = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_WIDTH'(1);
        wr_used_addr = head.sof ? '0 : wr_seq_addr;

        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        wbuf_d      = wbuf_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        rd_active_d = rd_active_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        starve_d    = starve_q;
        ovf_d       = ovf_q | drop;

        if (state_d == WRITE) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = wr_used_addr;
            o_mem_wdata = head.dat;
            rp_d        = rp_q + PW'(1);
            wr_addr_d   = wr_used_addr;
        end else if (state_d == READ) begin
            o_mem_en   = 1'b1;
            o_mem_addr = rd_addr_q;
            if (rd_addr_q == LAST_ADDR) begin
                rd_active_d = 1'b0;
                rd_addr_d   = '0;
            end else begin
                rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            end
        end

        // A request only starts a frame when none is in progress
        if (i_req && !rd_active_q) begin
            rd_active_d = 1'b1;
            rd_addr_d   = '0;
        end

        if (push) begin
            wbuf_d[wp_q] = '{sof: i_sof, dat: i_wdata};
            wp_d         = wp_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (state_d == READ || !rd_elig)    starve_d = '0;
        else if (starve_q < SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            rd_active_q <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            starve_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            rd_active_q <= rd_active_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            starve_q    <= starve_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        wbuf_q <= wbuf_d;
    end

    // Read data arrives the cycle after issue; reset suppresses the pending pulse
    assign o_wr        = (state_q == READ) & ~i_rst;
    assign o_wdata     = o_wr ? i_mem_rdata : '0;
    assign o_woverflow = ovf_q;

`ifdef BRAM_ARBITER_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    assign o_drop_cnt = 16'd0;
`endif
endmodule
